addsub_serial_unit: RTL and testbench

- Parametrised, multi-cycle add/subtract unit for the calculator datapath.
- Processes a WIDTH-bit operation CHUNK bits per clock, holding the carry in a register between chunks.
- Reports carry, signed overflow, zero and negative flags.
- Valid/ready handshakes on both sides, so it sits between the operand/key-decode stage and the result/display stage.

---
 rtl/addsub_serial_unit.sv | 149 ++++++++++++++
 tb/tb_addsub_serial_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_unit.sv
// addsub_serial_unit
// Multi-cycle add/subtract unit for the calculator datapath. A WIDTH-bit
// operation is processed CHUNK bits per clock, with the carry held in a
// register between chunks. Results carry the usual carry/overflow/zero/neg
// flags and are handed off through a valid/ready handshake on each side.
//
// Parameters:
//   WIDTH  operand/result width (multiple of CHUNK)
//   CHUNK  bits added per clock; NCHUNK = WIDTH/CHUNK cycles per operation
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands/op presented        in_ready   unit idle, will accept
//   a, b       operands                     op         00 a+b, 01 a-b,
//   cin        carry-in (op=11 only)                   10 b-a, 11 a+b+cin
//   out_valid  result/flags valid           out_ready  consumer takes result
//   s          result                       cout       carry out (1 = no borrow)
//   ovf        signed overflow              zero/neg   s==0 / s[WIDTH-1]
//
// Optional build macro ADDSUB_SATURATE_EN: on signed overflow, s is clamped
// to the signed max or min instead of wrapping. Without it, s wraps.

module addsub_serial_unit #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] acc;

  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] s_final;
  logic             ovf_final;

  // One chunk of the ripple: add the selected slices of X and Y plus the
  // held carry, and splice the partial sum into the accumulator. On the last
  // chunk acc_next is the complete sum, so the flags are derived from it.
  always_comb begin
    int base;
    base      = int'(cnt) * CHUNK;
    chunk_add = {1'b0, x_reg[base +: CHUNK]} + {1'b0, y_reg[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    acc_next  = acc;
    acc_next[base +: CHUNK] = chunk_add[CHUNK-1:0];
    ovf_final = (x_reg[WIDTH-1] == y_reg[WIDTH-1]) &&
                (acc_next[WIDTH-1] != x_reg[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    // Positive overflow (X msb 0) clamps to max, negative to min.
    if (ovf_final)
      s_final = x_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    else
      s_final = acc_next;
`else
    s_final = acc_next;
`endif
  end

  // Control FSM and datapath registers. Subtraction is folded into addition
  // at acceptance (invert one operand, seed the carry with 1), so BUSY only
  // ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      acc       <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (op)
              2'b00: begin x_reg <= a; y_reg <= b;  carry <= 1'b0; end
              2'b01: begin x_reg <= a; y_reg <= ~b; carry <= 1'b1; end
              2'b10: begin x_reg <= b; y_reg <= ~a; carry <= 1'b1; end
              2'b11: begin x_reg <= a; y_reg <= b;  carry <= cin;  end
            endcase
            cnt      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          carry <= chunk_add[CHUNK];
          if (cnt == LAST) begin
            s         <= s_final;
            cout      <= chunk_add[CHUNK];
            ovf       <= ovf_final;
            zero      <= (s_final == '0);
            neg       <= s_final[WIDTH-1];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Testbench for addsub_serial_unit (WIDTH=10, CHUNK=2). Inputs are driven on
// the falling edge, outputs sampled on the falling edge. Expected results come
// from a plain-integer reference model of the arithmetic.

module tb_addsub_serial_unit;

  localparam int W = 10;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  addsub_serial_unit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero),
    .neg(neg)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Safety net in case some wait goes unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the arithmetic result as integers, signed overflow as range
  // escape, carry/no-borrow as unsigned comparisons.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] mop, input logic mc);
    res_t r;
    int ai, bi, sa, sb, ures, sres, full, half;
    r    = '0;
    full = 1 << W;
    half = 1 << (W - 1);
    ai   = int'(ma);
    bi   = int'(mb);
    sa   = (ai >= half) ? ai - full : ai;
    sb   = (bi >= half) ? bi - full : bi;
    ures = 0;
    sres = 0;
    case (mop)
      2'b00: begin ures = ai + bi; r.cout = (ures >= full); sres = sa + sb; end
      2'b01: begin ures = ai - bi; r.cout = (ai >= bi);     sres = sa - sb; end
      2'b10: begin ures = bi - ai; r.cout = (bi >= ai);     sres = sb - sa; end
      default: begin
        ures = ai + bi + int'(mc); r.cout = (ures >= full);
        sres = sa + sb + int'(mc);
      end
    endcase
    r.s   = W'(((ures % full) + full) % full);
    r.ovf = (sres > half - 1) || (sres < -half);
`ifdef ADDSUB_SATURATE_EN
    if (r.ovf) r.s = (sres > 0) ? W'(half - 1) : W'(half);
`endif
    r.zero = (r.s == '0);
    r.neg  = r.s[W-1];
    return r;
  endfunction

  function automatic res_t observed();
    return {s, cout, ovf, zero, neg};
  endfunction

  // Present an operation and return just after the edge that accepts it.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic [1:0] top, input logic tcin);
    @(negedge clk);
    a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1;
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
  endtask

  // Wait for out_valid; lat counts falling edges after the accept edge.
  task automatic waitResult(output res_t r, output int lat);
    lat = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 0) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = j;
        break;
      end
    end
    r = observed();
  endtask

  // Hold the result hold cycles, then complete the output handshake.
  task automatic releaseResult(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    #2;
    checks++;
    if (observed() !== res_t'('0) || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h/%b expected 0/0", observed(), out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0",
               in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         cin;
    res_t         exp;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    res_t r;
    int   lat;
    v[0] = '{10'h12C, 10'h0C8, 2'b00, 1'b0, '{10'h1F4, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[1] = '{10'h005, 10'h007, 2'b01, 1'b0, '{10'h3FE, 1'b0, 1'b0, 1'b0, 1'b1}};
    v[2] = '{10'h003, 10'h00A, 2'b10, 1'b0, '{10'h007, 1'b1, 1'b0, 1'b0, 1'b0}};
`ifdef ADDSUB_SATURATE_EN
    v[3] = '{10'h1FF, 10'h001, 2'b00, 1'b0, '{10'h1FF, 1'b0, 1'b1, 1'b0, 1'b0}};
    v[4] = '{10'h200, 10'h001, 2'b01, 1'b0, '{10'h200, 1'b1, 1'b1, 1'b0, 1'b1}};
`else
    v[3] = '{10'h1FF, 10'h001, 2'b00, 1'b0, '{10'h200, 1'b0, 1'b1, 1'b0, 1'b1}};
    v[4] = '{10'h200, 10'h001, 2'b01, 1'b0, '{10'h1FF, 1'b1, 1'b1, 1'b0, 1'b0}};
`endif
    v[5] = '{10'h3FF, 10'h000, 2'b11, 1'b1, '{10'h000, 1'b1, 1'b0, 1'b1, 1'b0}};
    v[6] = '{10'h3FF, 10'h000, 2'b11, 1'b0, '{10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(v[i].a, v[i].b, v[i].op, v[i].cin);
      waitResult(r, lat);
      checks++;
      if (r !== v[i].exp) begin
        errors++;
        $display("[TB] FAIL directed_%0d: got s=%h c=%b v=%b z=%b n=%b expected s=%h c=%b v=%b z=%b n=%b",
                 i, r.s, r.cout, r.ovf, r.zero, r.neg, v[i].exp.s, v[i].exp.cout,
                 v[i].exp.ovf, v[i].exp.zero, v[i].exp.neg);
      end
      checks++;
      if (lat != N) begin
        errors++;
        $display("[TB] FAIL latency_%0d: got %0d expected %0d", i, lat, N);
      end
      releaseResult(0);
    end
  endtask

  task automatic test_random();
    res_t r, e;
    int   lat;
    logic [W-1:0] ta, tb;
    logic [1:0]   top;
    logic         tc;
    for (int i = 0; i < 40; i++) begin
      ta  = W'($urandom_range(0, (1 << W) - 1));
      tb  = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 3) == 0) ta = 10'h1FF;
      if ($urandom_range(0, 3) == 0) tb = 10'h200;
      top = 2'($urandom_range(0, 3));
      tc  = 1'($urandom_range(0, 1));
      e   = model(ta, tb, top, tc);
      applyStimulus(ta, tb, top, tc);
      waitResult(r, lat);
      checks++;
      if (r !== e || lat != N) begin
        errors++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h cin=%b: got %h lat %0d expected %h lat %0d",
                 i, top, ta, tb, tc, r, lat, e, N);
      end
      releaseResult($urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    time  t1, t2;
    res_t r, e;
    int   lat;
    out_ready = 1'b1;
    applyStimulus(10'h0AB, 10'h155, 2'b00, 1'b0);
    t1 = $time;
    @(negedge clk);
    a = 10'h2F0; b = 10'h111; op = 2'b10; cin = 1'b1;
    for (int i = 0; i < 30 && in_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    t2 = $time;
    e = model(10'h2F0, 10'h111, 2'b10, 1'b1);
    checks++;
    if ((t2 - t1) / 10 != N + 2) begin
      errors++;
      $display("[TB] FAIL throughput: got %0d cycles expected %0d", (t2 - t1) / 10, N + 2);
    end
    waitResult(r, lat);
    checks++;
    if (r !== e || lat != N) begin
      errors++;
      $display("[TB] FAIL back_to_back_result: got %h lat %0d expected %h lat %0d", r, lat, e, N);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    res_t r1, r2, e1, e2;
    int   j;
    out_ready = 1'b0;
    e1 = model(10'h155, 10'h0AA, 2'b01, 1'b0);
    e2 = model(10'h07F, 10'h3C0, 2'b00, 1'b0);
    applyStimulus(10'h155, 10'h0AA, 2'b01, 1'b0);
    @(negedge clk);
    a = 10'h07F; b = 10'h3C0; op = 2'b00; cin = 1'b1;
    for (j = 0; j < 30; j++) begin
      if (out_valid === 1'b1) break;
      @(negedge clk);
    end
    r1 = observed();
    checks++;
    if (r1 !== e1) begin
      errors++;
      $display("[TB] FAIL bp_first_result: got %h expected %h", r1, e1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== r1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got %h in_ready=%b out_valid=%b expected %h 0 1",
                 i, observed(), in_ready, out_valid, r1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_after_handshake: got in_ready=%b out_valid=%b expected 1/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_second_accept: got in_ready=%b expected 0", in_ready);
    end
    for (j = 1; j < 30; j++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    r2 = observed();
    checks++;
    if (r2 !== e2 || j != N) begin
      errors++;
      $display("[TB] FAIL bp_second_result: got %h lat %0d expected %h lat %0d", r2, j, e2, N);
    end
    releaseResult(0);
  endtask

  task automatic test_reset_midbusy();
    res_t r, e;
    int   lat;
    bit   stale;
    applyStimulus(10'h3AB, 10'h0CD, 2'b11, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy_assert: got out_valid=%b in_ready=%b expected 0/1",
               out_valid, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== '0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("[TB] FAIL reset_busy_release: got stale state out_valid=%b in_ready=%b s=%h expected 0/1/000",
               out_valid, in_ready, s);
    end
    e = model(10'h123, 10'h321, 2'b01, 1'b0);
    applyStimulus(10'h123, 10'h321, 2'b01, 1'b0);
    waitResult(r, lat);
    checks++;
    if (r !== e || lat != N) begin
      errors++;
      $display("[TB] FAIL reset_busy_next_op: got %h lat %0d expected %h lat %0d", r, lat, e, N);
    end
    releaseResult(0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midbusy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
